spi_tx_feeder: RTL

// - Byte-buffering front end that sits directly upstream of the SPI master.
// - Accepts bytes from system logic into a FIFO and presents them one at a time on spi_output_reg/data_valid.
// - Follows the master's handshake: hold data_valid until spi_done rises, drop it, wait for spi_done to fall.
// - Lets software queue bursts without polling each byte.

---
 rtl/spi_tx_feeder_pkg.sv | 15 +
 rtl/spi_byte_fifo.sv | 67 ++++++
 rtl/spi_tx_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_tx_feeder_pkg.sv
// Shared types and defaults for the SPI transmit byte feeder.
package spi_tx_feeder_pkg;

  localparam int unsigned SPI_DATA_W       = 8;
  localparam int unsigned FIFO_DEPTH       = 16;
  localparam int unsigned DONE_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous FIFO with registered level/full/empty and a first-word head
// that is valid whenever the FIFO is non-empty.
module spi_byte_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       head_c,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_c, pop_c;

  // A write into a full FIFO is accepted only when a pop frees a slot the same cycle.
  always_comb begin
    pop_c    = rd_en && !empty_q;
    push_c   = wr_en && (!full_q || pop_c);
    wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_c) - LW'(pop_c);
    full_d   = (level_d == LW'(DEPTH));
    empty_d  = (level_d == LW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign head_c = mem_q[rd_ptr_q];
  assign full   = full_q;
  assign empty  = empty_q;
  assign level  = level_q;

endmodule

// File: rtl/spi_tx_feeder.sv
// Byte-buffering front end for the SPI master: queues bytes and hands them
// over one at a time using the data_valid / spi_done handshake.
module spi_tx_feeder
  import spi_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH       = FIFO_DEPTH,
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = DONE_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_en,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    clr_overflow,
  output logic [DATA_W-1:0]       spi_output_reg,
  output logic                    data_valid,
  input  logic                    spi_done,
  output logic                    busy,
  output logic [15:0]             bytes_sent
);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;
  logic                   done_s;
  feeder_state_e          state_q, state_d;
  logic [DATA_W-1:0]      spi_output_reg_q, spi_output_reg_d;
  logic                   data_valid_q, data_valid_d;
  logic                   busy_q, busy_d;
  logic [15:0]            bytes_sent_q, bytes_sent_d;
  logic                   overflow_q, overflow_d;
  logic                   pop_c;
  logic [DATA_W-1:0]      head_c;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  spi_byte_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_c),
    .head_c  (head_c),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign done_sync_d = {done_sync_q[SYNC_STAGES-2:0], spi_done};
  assign done_s      = done_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d          = state_q;
    pop_c            = 1'b0;
    spi_output_reg_d = spi_output_reg_q;
    data_valid_d     = data_valid_q;
    bytes_sent_d     = bytes_sent_q;
    unique case (state_q)
      // A done still high from a previous byte (or across reset) blocks the next load.
      ST_IDLE: begin
        data_valid_d = 1'b0;
        if (!empty && !done_s) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop_c            = 1'b1;
        spi_output_reg_d = head_c;
        data_valid_d     = 1'b1;
        state_d          = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        data_valid_d = 1'b1;
        if (done_s) begin
          data_valid_d = 1'b0;
          bytes_sent_d = bytes_sent_q + 16'd1;
          state_d      = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        data_valid_d = 1'b0;
        if (!done_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    // Sticky overflow: a dropped write beats a same-cycle clear.
    if (wr_en && full && !pop_c) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_sync_q      <= '0;
      state_q          <= ST_IDLE;
      spi_output_reg_q <= '0;
      data_valid_q     <= 1'b0;
      busy_q           <= 1'b0;
      bytes_sent_q     <= '0;
      overflow_q       <= 1'b0;
    end else begin
      done_sync_q      <= done_sync_d;
      state_q          <= state_d;
      spi_output_reg_q <= spi_output_reg_d;
      data_valid_q     <= data_valid_d;
      busy_q           <= busy_d;
      bytes_sent_q     <= bytes_sent_d;
      overflow_q       <= overflow_d;
    end
  end

  assign spi_output_reg = spi_output_reg_q;
  assign data_valid     = data_valid_q;
  assign busy           = busy_q;
  assign bytes_sent     = bytes_sent_q;
  assign overflow       = overflow_q;

endmodule
